// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_if
//  Brief    : Decode-side handshake and instruction-memory bus of the fetch unit.
//  Revision : 1.0
// ============================================================================
interface instruction_fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] PC_1;
    logic        if_valid;

    modport master (
        input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, instruction, PC_1, if_valid
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instruction, PC_1, if_valid
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Brief    : Single-request fetch stage with one-entry skid buffer and
//             redirect drain handling.
//  Revision : 1.0
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    instruction_fetch_if.master   bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc1_q;
    logic        valid_q;
    logic        req_q;
    logic [31:0] skid_q;
    logic [31:0] target_q;
    logic [31:0] pc_inc_d;

    assign pc_inc_d = pc_q + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            pc1_q    <= 32'd0;
            valid_q  <= 1'b0;
            req_q    <= 1'b0;
            skid_q   <= 32'd0;
            target_q <= 32'd0;
        end else begin
            unique case (state_q)
                BOOT: begin
                    if (bus.redirect) begin
                        pc_q    <= bus.redirect_pc;
                        instr_q <= 32'd0;
                        valid_q <= 1'b0;
                    end
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (bus.redirect) begin
                        instr_q <= 32'd0;
                        valid_q <= 1'b0;
                        if (bus.imem_ack) begin
                            pc_q <= bus.redirect_pc;
                        end else begin
                            // Request still in flight: address must stay put until it retires.
                            target_q <= bus.redirect_pc;
                            state_q  <= DRAIN;
                        end
                    end else if (bus.stall) begin
                        if (bus.imem_ack) begin
                            skid_q  <= bus.imem_rdata;
                            pc_q    <= pc_inc_d;
                            state_q <= HELD;
                            req_q   <= 1'b0;
                        end
                    end else if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        pc1_q   <= pc_inc_d;
                        valid_q <= 1'b1;
                        pc_q    <= pc_inc_d;
                    end else begin
                        instr_q <= 32'd0;
                        valid_q <= 1'b0;
                    end
                end
                HELD: begin
                    if (bus.redirect) begin
                        instr_q <= 32'd0;
                        valid_q <= 1'b0;
                        pc_q    <= bus.redirect_pc;
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end else if (!bus.stall) begin
                        // pc_q was already advanced when the skid entry was captured.
                        instr_q <= skid_q;
                        pc1_q   <= pc_q;
                        valid_q <= 1'b1;
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end
                end
                DRAIN: begin
                    instr_q <= 32'd0;
                    valid_q <= 1'b0;
                    if (bus.redirect) begin
                        target_q <= bus.redirect_pc;
                    end
                    if (bus.imem_ack) begin
                        pc_q    <= bus.redirect ? bus.redirect_pc : target_q;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= BOOT;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instruction = instr_q;
    assign bus.PC_1        = pc1_q;
    assign bus.if_valid    = valid_q;

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word address of the first fetch after reset SHALL be this value.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; reset==0 SHALL immediately force the reset state.
REQ-004 stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-005 redirect  input  1  branch/jump taken; flush and refetch.
REQ-006 redirect_pc  input  32  word address of the redirect target.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  word address of the request.
REQ-009 imem_ack  input  1  imem_rdata valid for the current request; may arrive in the request cycle or later.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instruction  output  32  registered instruction to decode.
REQ-012 PC_1  output  32  registered address of instruction plus 1.
REQ-013 if_valid  output  1  instruction/PC_1 hold a real fetched instruction.

Function
REQ-014 Internal pc register SHALL hold the next fetch address; all PC arithmetic SHALL be 32-bit unsigned, wrapping 32'hFFFF_FFFF+1 to 0.
REQ-015 FSM states: BOOT, FETCH, HELD, DRAIN; reset state BOOT.
REQ-016 BOOT: imem_req=0; next cycle SHALL go to FETCH.
REQ-017 FETCH: imem_req=1, imem_addr=pc; addr SHALL remain stable until imem_ack.
REQ-018 FETCH, imem_ack=1, stall=0, redirect=0: instruction<=imem_rdata, PC_1<=pc+1, if_valid<=1, pc<=pc+1; stay FETCH.
REQ-019 FETCH, imem_ack=0, stall=0, redirect=0: instruction<=0 (bubble), if_valid<=0, PC_1 holds.
REQ-020 FETCH, stall=1, redirect=0: output registers hold; if imem_ack=1, imem_rdata and pc+1 SHALL be captured in a one-entry skid buffer, pc<=pc+1, go HELD.
REQ-021 HELD: imem_req=0; when stall=0 the buffer SHALL load into instruction/PC_1 with if_valid<=1, go FETCH.
REQ-022 Redirect SHALL take priority over stall in every state: output registers load the bubble (instruction=0, if_valid=0) on that edge.
REQ-023 Redirect in FETCH with imem_ack=1 or in HELD/BOOT: response/buffer discarded, pc<=redirect_pc, go FETCH.
REQ-024 Redirect in FETCH with imem_ack=0: redirect_pc saved, go DRAIN; DRAIN keeps imem_req=1 and old imem_addr until imem_ack, discards the data, then pc<=saved target, go FETCH.
REQ-025 Redirect while in DRAIN SHALL overwrite the saved target; outputs stay bubble throughout DRAIN.
REQ-026 Bubble value 32'h0000_0000 SHALL be the only instruction value presented with if_valid=0.
REQ-027 Latency: instruction visible one edge after the acknowledging edge when not stalled; sustained throughput one instruction per cycle with single-cycle memory.

Reset
REQ-028 On reset==0: state=BOOT, pc=RESET_PC, instruction=0, PC_1=0, if_valid=0, imem_req=0, skid buffer empty, saved target=0.
REQ-029 Reset asserted mid-request SHALL abandon the request; a late imem_ack after release SHALL be ignored until the first FETCH request is issued.

Verification
REQ-030 Release reset, memory acks same cycle with rdata=addr+32'h100 -> imem_addr 0,1,2,...; instruction 0x100,0x101,... with PC_1 1,2,3, if_valid=1 each cycle after the first fetch.
REQ-031 Ack 3 cycles late for addr 5 -> imem_addr held at 5 for 3 cycles, if_valid=0 and instruction=0 during wait, then instruction=rdata, PC_1=6.
REQ-032 stall=1 for 4 cycles while ack arrives for addr 7 -> outputs frozen, state HELD, imem_req=0; stall drops -> instruction=rdata(7), PC_1=8, next imem_addr=8.
REQ-033 redirect=1, redirect_pc=0x40 with stall=1 and ack outstanding -> bubble next edge, old address held until ack, next request addr 0x40, first valid PC_1=0x41.
REQ-034 pc=32'hFFFF_FFFF fetched -> PC_1=0, next imem_addr=0.
REQ-035 reset pulsed low during DRAIN -> all outputs zero asynchronously, first request after release at RESET_PC.
